// File: rtl/rs_receiver_pkg.sv
// Shared constants and state encoding for the RS-232 8N1 receiver.
package rs_receiver_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned HALF_BIT_DEF     = 217;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned BIT_IDX_W        = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rs_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input; both stages reset to 1.
module rs_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rs_receiver.sv
// RS-232 8N1 receiver: oversamples RX, assembles one byte per frame and
// reports completion with RS_DONE or a bad stop bit with FRAME_ERR.
module rs_receiver
    import rs_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned HALF_BIT     = HALF_BIT_DEF
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       RS_DONE,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    rs_rx_sync u_rx_sync (
        .clk (CLK_50MHZ),
        .rst (RST),
        .d   (RX),
        .q   (rx_s)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            // Line must be continuously high for a full bit before we trust an edge.
            ST_WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == BIT_END) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            // Leaving at stop mid-bit gives half a bit of slack for a back-to-back start.
            ST_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    assign DATA      = data_q;
    assign RS_DONE   = done_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = busy_q;

endmodule

// File: doc/rs_receiver.md
Name: rs_receiver

Overview:
Asynchronous RS-232 receiver (8N1) that sits directly upstream of the transfer manager FSM. It oversamples the serial RX line with the 50 MHz system clock and assembles one byte per frame. It signals each completed byte to the manager with a single-cycle RS_DONE pulse and holds DATA stable until the next good frame. Framing errors are flagged separately and never produce RS_DONE.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200 baud).
HALF_BIT, 217, clocks from start-edge detection to the start-bit mid-sample (CLKS_PER_BIT/2).

Ports:
CLK_50MHZ  input  1  system clock, 50 MHz
RST  input  1  reset, synchronous, active-high
RX  input  1  asynchronous serial line; idle high
DATA  output  8  last correctly received byte, LSB first on the line
RS_DONE  output  1  one-cycle pulse: DATA has just been updated
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
BUSY  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset values: DATA=8'h00, RS_DONE=0, FRAME_ERR=0, BUSY=0, bit counter=0, clock counter=0, state=WAIT_IDLE.
- Synchronizer:
  - RX passes through 2 flops, both reset to 1. All logic uses the synchronized value rx_s.
  - Input latency is 2 cycles.
- WAIT_IDLE:
  - rx_s must stay high for CLKS_PER_BIT consecutive cycles. Any low sample restarts the count.
  - When the count completes, go to IDLE.
  - Purpose: avoids false start on a line held low or mid-frame at reset, and recovers after a break.
- IDLE:
  - A low rx_s starts the frame: go to START, clear the clock counter, BUSY=1.
- START:
  - At count HALF_BIT-1, sample rx_s.
  - If 1, it was a glitch: go to IDLE, BUSY=0, no outputs pulsed.
  - If 0, go to DATA with bit index 0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index], LSB first.
  - After index 7, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rx_s.
  - If 1: load DATA from the shift register, pulse RS_DONE for exactly 1 cycle, go to IDLE.
  - If 0: pulse FRAME_ERR for 1 cycle, leave DATA unchanged, go to WAIT_IDLE.
- Latency: RS_DONE rises the cycle after the stop mid-sample, i.e. 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 = 4126 cycles after the RX falling edge (±1 for edge alignment).
- Back-to-back frames: returning to IDLE at stop mid-bit leaves half a bit to detect the next start edge. Zero idle gap between frames must work.
- RS_DONE and FRAME_ERR are never high in the same cycle.
- DATA changes only in the RS_DONE cycle.
- RST mid-frame: the partial byte is discarded, outputs return to reset values, and the block re-enters WAIT_IDLE.
- Counters: clock counter width is clog2(CLKS_PER_BIT). It saturates, never wraps, and is cleared on every state change.

Decomposition:
- Shared package:
  - state encodings: WAIT_IDLE, IDLE, START, DATA, STOP (3-bit)
  - CLKS_PER_BIT and HALF_BIT defaults
  - frame constant DATA_BITS=8
- One sub-module: rs_rx_sync, a 2-flop synchronizer with reset value 1, reusable for other asynchronous inputs.

Test Plan:
- Startup: RST for 5 cycles with RX high, then wait 434 cycles → state IDLE, all outputs 0, DATA=8'h00.
- Good frame: send 8'h55 at 434 clocks/bit → one RS_DONE pulse about 4126 cycles after the start edge, DATA=8'h55, FRAME_ERR never high.
- Glitch: RX low for 100 cycles, then high → no RS_DONE or FRAME_ERR, BUSY falls by cycle about 220. A following frame with 8'hC3 is received correctly.
- Framing error: send 8'hA7 with stop bit 0 → FRAME_ERR pulses once, no RS_DONE, DATA keeps its prior value. The next frame is ignored until RX has been high for 434 cycles.
- Back-to-back: 8'hA3 then 8'h0F with no idle gap → exactly two RS_DONE pulses 4340 cycles apart, DATA=8'hA3 then 8'h0F.
- Reset mid-frame: assert RST during bit 4 of 8'hFF → no RS_DONE, DATA=8'h00. The remainder of that frame is ignored, and the next frame with 8'h3C is received correctly.
